// File: rtl/regwr_arbiter_if.sv
// regwr_arbiter_if: write-port bus between the writeback requesters and the
// register-file decoder. The master side is the pipeline (requesters A/B plus
// the stall line); the slave side is the arbiter that drives the decoder.
interface regwr_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_dest;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_dest;
  logic [31:0] b_data;
  logic        b_ready;
  logic        stall;
  logic [4:0]  dec_d;
  logic        dec_e;
  logic [31:0] wr_data;
  logic        last_grant;

  modport master (
    output a_valid, a_dest, a_data,
    output b_valid, b_dest, b_data,
    output stall,
    input  a_ready, b_ready,
    input  dec_d, dec_e, wr_data, last_grant
  );

  modport slave (
    input  a_valid, a_dest, a_data,
    input  b_valid, b_dest, b_data,
    input  stall,
    output a_ready, b_ready,
    output dec_d, dec_e, wr_data, last_grant
  );
endinterface

// File: rtl/regwr_arbiter.sv
// regwr_arbiter: shares the register file's single write port between the ALU
// writeback (A) and the memory load return (B). Grants are round-robin on
// contention; the winning write is registered and presented to the 5-to-32
// decoder as a one-cycle enable strobe the cycle after the handshake.
// Optional build macro REGWR_ZERO_DROP_EN: writes to register 0 are still
// accepted but never strobed, so r0 is never written.
module regwr_arbiter (
  input  logic          clk,
  input  logic          reset_n,
  regwr_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        grant_a;
  logic        grant_b;
  logic        transfer;
  logic        strobe_next;
  logic [4:0]  win_dest;
  logic [31:0] win_data;
  logic [4:0]  dec_d_q;
  logic [31:0] wr_data_q;
  logic        last_grant_q;

  // Grant selection: reset or stall blocks everyone; a lone requester wins;
  // on contention the requester not granted last time wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset_n && !bus.stall) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = last_grant_q;
        grant_b = !last_grant_q;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  // Winner mux and whether this transfer produces a strobe next cycle.
  always_comb begin
    transfer = grant_a | grant_b;
    win_dest = grant_b ? bus.b_dest : bus.a_dest;
    win_data = grant_b ? bus.b_data : bus.a_data;
`ifdef REGWR_ZERO_DROP_EN
    strobe_next = transfer && (win_dest != 5'd0);
`else
    strobe_next = transfer;
`endif
  end

  // State register; reset drops any in-flight strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a strobing transfer always lands in WRITE, so back-to-back
  // commits keep the machine in WRITE one cycle per write.
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = strobe_next ? WRITE : IDLE;
      WRITE:   state_next = strobe_next ? WRITE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write payload and round-robin pointer; both hold when nothing transfers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_d_q      <= 5'd0;
      wr_data_q    <= 32'd0;
      last_grant_q <= 1'b1;
    end else if (transfer) begin
      dec_d_q      <= win_dest;
      wr_data_q    <= win_data;
      last_grant_q <= grant_b;
    end
  end

  // Outputs: readies are the combinational grants, the strobe is the state.
  always_comb begin
    bus.a_ready    = grant_a;
    bus.b_ready    = grant_b;
    bus.dec_e      = (state == WRITE);
    bus.dec_d      = dec_d_q;
    bus.wr_data    = wr_data_q;
    bus.last_grant = last_grant_q;
  end

endmodule

// File: tb/tb_regwr_arbiter.sv
// tb_regwr_arbiter: directed test of the write-port arbiter. A cycle-level
// model of the grant and commit rules is checked against the DUT every cycle,
// and the directed sequences pin the model with hand-computed values.
module tb_regwr_arbiter;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;
  bit   modelKnown;

  logic [4:0]  mDecD;
  logic [31:0] mData;
  logic        mDecE;
  logic        mLast;
  logic [31:0] obsRf [32];

  regwr_arbiter_if bus ();

  regwr_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive every requester-side input in one go
  task automatic applyStimulus(input logic rn,
                               input logic av, input logic [4:0] ad, input logic [31:0] adt,
                               input logic bv, input logic [4:0] bd, input logic [31:0] bdt,
                               input logic st);
    reset_n     = rn;
    bus.a_valid = av;
    bus.a_dest  = ad;
    bus.a_data  = adt;
    bus.b_valid = bv;
    bus.b_dest  = bd;
    bus.b_data  = bdt;
    bus.stall   = st;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Who the rules say wins right now: 0 none, 1 A, 2 B
  function automatic int winner();
    if (!reset_n || bus.stall) return 0;
    if (bus.a_valid && bus.b_valid) return mLast ? 1 : 2;
    if (bus.a_valid) return 1;
    if (bus.b_valid) return 2;
    return 0;
  endfunction

  // Model of what the write port must present after each edge
  always @(posedge clk) begin
    automatic int w = winner();
    if (!reset_n) begin
      mDecE      <= 1'b0;
      mDecD      <= 5'd0;
      mData      <= 32'd0;
      mLast      <= 1'b1;
      modelKnown <= 1'b1;
    end else if (w == 1) begin
      mDecD <= bus.a_dest;
      mData <= bus.a_data;
      mLast <= 1'b0;
`ifdef REGWR_ZERO_DROP_EN
      mDecE <= (bus.a_dest != 5'd0);
`else
      mDecE <= 1'b1;
`endif
    end else if (w == 2) begin
      mDecD <= bus.b_dest;
      mData <= bus.b_data;
      mLast <= 1'b1;
`ifdef REGWR_ZERO_DROP_EN
      mDecE <= (bus.b_dest != 5'd0);
`else
      mDecE <= 1'b1;
`endif
    end else begin
      mDecE <= 1'b0;
    end
  end

  // Mid-cycle comparison against the model, and register-file shadow
  always @(negedge clk) begin
    automatic int w = winner();
    if (modelKnown) begin
      checkOutput("cmp_a_ready", 32'(bus.a_ready), 32'(w == 1));
      checkOutput("cmp_b_ready", 32'(bus.b_ready), 32'(w == 2));
      checkOutput("cmp_dec_e", 32'(bus.dec_e), 32'(mDecE));
      checkOutput("cmp_dec_d", 32'(bus.dec_d), 32'(mDecD));
      checkOutput("cmp_wr_data", bus.wr_data, mData);
      checkOutput("cmp_last_grant", 32'(bus.last_grant), 32'(mLast));
    end
    if (bus.dec_e === 1'b1) obsRf[bus.dec_d] = bus.wr_data;
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    modelKnown = 1'b0;
    mDecE = 1'b0; mDecD = 5'd0; mData = 32'd0; mLast = 1'b1;
    for (int i = 0; i < 32; i++) obsRf[i] = 32'd0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_dec_e", 32'(bus.dec_e), 32'd0);
    checkOutput("rst_dec_d", 32'(bus.dec_d), 32'd0);
    checkOutput("rst_wr_data", bus.wr_data, 32'd0);
    checkOutput("rst_last_grant", 32'(bus.last_grant), 32'd1);

    // Single write from A
    applyStimulus(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("single_a_ready", 32'(bus.a_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("single_dec_e", 32'(bus.dec_e), 32'd1);
    checkOutput("single_dec_d", 32'(bus.dec_d), 32'd7);
    checkOutput("single_wr_data", bus.wr_data, 32'hDEADBEEF);
    tick();
    checkOutput("single_dec_e_off", 32'(bus.dec_e), 32'd0);
    checkOutput("single_dec_d_hold", 32'(bus.dec_d), 32'd7);

    // Lone B write to the top register with all-ones data
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0);
    checkOutput("top_b_ready", 32'(bus.b_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("top_dec_d", 32'(bus.dec_d), 32'd31);
    checkOutput("top_wr_data", bus.wr_data, 32'hFFFFFFFF);
    checkOutput("top_last_grant", 32'(bus.last_grant), 32'd1);
    tick();

    // Contention from reset: A, B, A, B back to back
    applyStimulus(1'b0, 1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, 1'b0);
    checkOutput("cont_rst_a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, 1'b0);
    checkOutput("cont_first_a_ready", 32'(bus.a_ready), 32'd1);
    checkOutput("cont_first_b_ready", 32'(bus.b_ready), 32'd0);
    tick();
    checkOutput("cont1_dec_d", 32'(bus.dec_d), 32'd3);
    checkOutput("cont1_last", 32'(bus.last_grant), 32'd0);
    tick();
    checkOutput("cont2_dec_d", 32'(bus.dec_d), 32'd4);
    checkOutput("cont2_wr_data", bus.wr_data, 32'd2);
    checkOutput("cont2_dec_e", 32'(bus.dec_e), 32'd1);
    tick();
    checkOutput("cont3_dec_d", 32'(bus.dec_d), 32'd3);
    checkOutput("cont3_dec_e", 32'(bus.dec_e), 32'd1);
    tick();
    checkOutput("cont4_dec_d", 32'(bus.dec_d), 32'd4);
    checkOutput("cont4_last", 32'(bus.last_grant), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();

    // Same-dest collision with last_grant = 0: B first, A last
    applyStimulus(1'b1, 1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22, 1'b0);
    checkOutput("coll_last_before", 32'(bus.last_grant), 32'd0);
    checkOutput("coll_b_ready", 32'(bus.b_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("coll_first_data", bus.wr_data, 32'h22);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("coll_second_data", bus.wr_data, 32'h11);
    tick();
    tick();
    checkOutput("coll_r9_final", obsRf[9], 32'h11);

    // Stall for three cycles with both valid, then release
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_a_ready", 32'(bus.a_ready), 32'd0);
      checkOutput("stall_b_ready", 32'(bus.b_ready), 32'd0);
      tick();
      checkOutput("stall_dec_e", 32'(bus.dec_e), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB, 1'b0);
    checkOutput("release_b_ready", 32'(bus.b_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("release_dec_e", 32'(bus.dec_e), 32'd1);
    checkOutput("release_dec_d", 32'(bus.dec_d), 32'd6);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("release2_dec_d", 32'(bus.dec_d), 32'd5);
    tick();

    // Register zero write from A
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h5, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("zero_a_ready", 32'(bus.a_ready), 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checkOutput("zero_dec_d", 32'(bus.dec_d), 32'd0);
    checkOutput("zero_wr_data", bus.wr_data, 32'h5);
    checkOutput("zero_last", 32'(bus.last_grant), 32'd0);
`ifdef REGWR_ZERO_DROP_EN
    checkOutput("zero_dec_e", 32'(bus.dec_e), 32'd0);
`else
    checkOutput("zero_dec_e", 32'(bus.dec_e), 32'd1);
`endif
    tick();

    // Reset lands on the cycle a strobe is in flight
    applyStimulus(1'b1, 1'b1, 5'd12, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    checkOutput("midrst_dec_e_pre", 32'(bus.dec_e), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    checkOutput("midrst_dec_e", 32'(bus.dec_e), 32'd0);
    checkOutput("midrst_dec_d", 32'(bus.dec_d), 32'd0);
    checkOutput("midrst_wr_data", bus.wr_data, 32'd0);
    checkOutput("midrst_last", 32'(bus.last_grant), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    checkOutput("midrst_no_strobe", 32'(bus.dec_e), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
